ssp_tx_arbiter: RTL
===================

Name: ssp_tx_arbiter

Overview:
Round-robin arbiter that shares one SSP transmit interface (do_write / tx_d / tx_full) among NUM_REQ byte-stream requesters. It grants one requester at a time for a burst of up to BURST_LEN bytes, or until that requester flags its last byte, then rotates. It sits between the system-side producers and the SSP transmit FIFO, in the clk_i domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BURST_LEN, 4, max bytes per grant before forced rotation (1..16)
IDX_W, $clog2(NUM_REQ), grant index width (derived)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  NUM_REQ  requester n has a byte on data_i[n]
data_i  in  8*NUM_REQ  byte from requester n at bits [8n+7:8n]
last_i  in  NUM_REQ  current byte of requester n ends its packet
ack_o  out  NUM_REQ  one-hot; byte of requester n accepted this cycle
gnt_vld_o  out  1  a grant is held
gnt_idx_o  out  IDX_W  index of granted requester
do_write  out  1  write strobe to SSP transmit FIFO
tx_d  out  8  byte to SSP transmit FIFO
tx_full  in  1  SSP transmit FIFO full

Behaviour:
- Reset (rst_ni low, asynchronous): state=ARB, rr_ptr=0, gnt_idx_o=0, gnt_vld_o=0, beat_cnt=0; ack_o=0, do_write=0, tx_d=0. Reset mid-burst drops the grant immediately; no partial-state recovery.
- FSM states: ARB, XFER.
- ARB: if req_i==0, stay. Otherwise pick the first set req_i bit scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ. Register gnt_idx_o, set gnt_vld_o=1, beat_cnt=0, go to XFER. No bytes move in ARB, so there is always a one-cycle gap between grants.
- XFER: write = req_i[g] && !tx_full, where g=gnt_idx_o.
  - do_write = write; ack_o = write << g (combinational).
  - tx_d = data_i[g] when in XFER, else 8'h00.
- Transfer handshake: a byte moves only in a cycle where both req_i[g] and !tx_full are high. The requester holds data_i/last_i stable until it sees ack_o.
- Burst end, taking effect on the next cycle: ARB, gnt_vld_o=0, rr_ptr=(g+1) mod NUM_REQ. It ends on any of:
  - (a) write && last_i[g];
  - (b) write && beat_cnt==BURST_LEN-1;
  - (c) !req_i[g], meaning the requester withdrew. No ack is issued for that cycle.
- Otherwise, on write, beat_cnt increments.
- tx_full high in XFER: stall. Grant is held, beat_cnt is unchanged, no ack.
- Simultaneous (a) and (b): a single end, same result.
- beat_cnt width is $clog2(BURST_LEN+1). It never wraps because the burst ends at BURST_LEN-1.
- Fairness: each requester waits at most NUM_REQ-1 grants.

Optional Feature:
Macro SSP_TX_ARB_PRIO_EN.
- Defined: requester 0 has strict priority in ARB. If req_i[0] is set, it is granted regardless of rr_ptr, and rr_ptr is not updated after its burst. All other requesters use round-robin among themselves.
- Not defined: pure round-robin as above.

Decomposition:
- Package ssp_pkg holds:
  - the state enum (ARB_S, XFER_S);
  - the byte width constant SSP_BYTE_W=8;
  - the default BURST_LEN.
- One sub-module, rr_pick: combinational round-robin first-set-bit finder (inputs req vector and rr_ptr; outputs idx and found). It is reused by a future receive-side arbiter.

Test Plan:
- Reset: drive req_i=4'b1111 and pulse rst_ni low mid-XFER -> same cycle gnt_vld_o=0, do_write=0, ack_o=0. After release, first grant goes to index 0.
- Round-robin: req_i=4'b1011 held, each requester sends 2 bytes with last_i on the 2nd, tx_full=0 -> grant order 0,1,3,0. tx_d sequence matches the data, with a one-cycle gap between grants.
- Burst cap: BURST_LEN=4, requester 2 streams 10 bytes with no last_i -> exactly 4 acks. Grant then rotates to the next requester, or back to 2 after ARB if it is alone.
- Backpressure: tx_full=1 for 3 cycles mid-burst -> do_write=0 and ack_o=0 during the stall, grant held, byte count unaffected. The transfer resumes with the same byte.
- Withdrawal: granted requester 1 drops req_i after 1 byte -> ARB next cycle, rr_ptr=2, no extra ack.
- SSP_TX_ARB_PRIO_EN defined: req_i=4'b0110 with requester 1 granted, then req_i[0] rises -> after 1's burst, 0 is granted before 2. With the macro undefined, 2 is granted first.

Source files
------------

// File: rtl/ssp_pkg.sv
// Shared types and constants for the SSP transmit/receive arbitration blocks.
package ssp_pkg;

    localparam int SSP_BYTE_W        = 8;
    localparam int DEFAULT_BURST_LEN = 4;

    typedef enum logic {
        ARB_S,
        XFER_S
    } arb_state_e;

    // Modulo increment used to advance a round-robin pointer past the last grant.
    function automatic int wrap_inc(input int value, input int modulus);
        return (value + 1) % modulus;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set bit of req scanning from ptr upward, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [IDX_W-1:0] pos;

    // Scan from the farthest offset back to ptr so the closest hit is written last.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            pos = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (req[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ssp_tx_arbiter.sv
// Round-robin arbiter sharing one SSP transmit FIFO port among NUM_REQ byte producers.
// Define SSP_TX_ARB_PRIO_EN to give requester 0 strict priority over the round-robin.
module ssp_tx_arbiter
    import ssp_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = DEFAULT_BURST_LEN,
    parameter int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [SSP_BYTE_W*NUM_REQ-1:0]    data_i,
    input  logic [NUM_REQ-1:0]               last_i,
    output logic [NUM_REQ-1:0]               ack_o,
    output logic                             gnt_vld_o,
    output logic [IDX_W-1:0]                 gnt_idx_o,
    output logic                             do_write,
    output logic [SSP_BYTE_W-1:0]            tx_d,
    input  logic                             tx_full
);

    localparam int              BEAT_W    = $clog2(BURST_LEN + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [SSP_BYTE_W-1:0] data_arr [NUM_REQ];
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_found;
    logic                  prio_hit;
    logic                  ptr_hold;
    logic                  write;
    logic                  burst_end;

    for (genvar n = 0; n < NUM_REQ; n++) begin : g_unpack
        assign data_arr[n] = data_i[n*SSP_BYTE_W +: SSP_BYTE_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (req_i),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

`ifdef SSP_TX_ARB_PRIO_EN
    // Requester 0 pre-empts the rotation and its bursts leave the pointer untouched.
    assign prio_hit = req_i[0];
    assign ptr_hold = (gnt_idx_q == '0);
`else
    assign prio_hit = 1'b0;
    assign ptr_hold = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_idx_d  = gnt_idx_q;
        gnt_vld_d  = gnt_vld_q;
        beat_cnt_d = beat_cnt_q;
        write      = 1'b0;
        burst_end  = 1'b0;
        tx_d       = '0;

        case (state_q)
            ARB_S: begin
                if (pick_found) begin
                    gnt_idx_d  = prio_hit ? '0 : pick_idx;
                    gnt_vld_d  = 1'b1;
                    beat_cnt_d = '0;
                    state_d    = XFER_S;
                end
            end

            XFER_S: begin
                tx_d  = data_arr[gnt_idx_q];
                write = req_i[gnt_idx_q] && !tx_full;
                // A withdrawn request ends the burst; a full FIFO only stalls it.
                burst_end = !req_i[gnt_idx_q]
                          || (write && (last_i[gnt_idx_q] || beat_cnt_q == LAST_BEAT));
                if (burst_end) begin
                    state_d   = ARB_S;
                    gnt_vld_d = 1'b0;
                    if (!ptr_hold) begin
                        rr_ptr_d = IDX_W'(wrap_inc(int'(gnt_idx_q), NUM_REQ));
                    end
                end else if (write) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ARB_S;
            end
        endcase
    end

    assign do_write  = write;
    assign ack_o     = NUM_REQ'(write) << gnt_idx_q;
    assign gnt_vld_o = gnt_vld_q;
    assign gnt_idx_o = gnt_idx_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB_S;
            rr_ptr_q   <= '0;
            gnt_idx_q  <= '0;
            gnt_vld_q  <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_vld_q  <= gnt_vld_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    a_ack_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(ack_o));
    a_ack_write:  assert property (@(posedge clk_i) disable iff (!rst_ni) (|ack_o) == do_write);

endmodule
